// File: rtl/blackjack_table_ctrl.sv
// blackjack_table_ctrl: multi-seat blackjack sequencer sitting between the
// user buttons and the deck. Runs shuffle, the two-round deal, seat play,
// the house draw rule and final scoring, and exports sums and results.
module blackjack_table_ctrl #(
  parameter int NUM_PLAYERS = 2,
  parameter int HAND_DEPTH  = 5,
  parameter int HOUSE_STAND = 17,
  parameter int BUST_LIMIT  = 21,
  parameter int SUM_W       = 6,
  parameter int SEAT_W      = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         hit,
  input  logic                         stand,
  output logic                         shuffle_start,
  input  logic                         shuffle_ready,
  output logic                         card_start,
  input  logic                         card_ready,
  input  logic [3:0]                   card,
  input  logic                         card_overflow,
  output logic [SEAT_W-1:0]            active_seat,
  output logic [NUM_PLAYERS*SUM_W-1:0] player_sums,
  output logic [SUM_W-1:0]             house_sum,
  output logic [2*NUM_PLAYERS-1:0]     results,
  output logic                         await_input,
  output logic                         game_done,
  output logic                         error
);

  // Hand index NUM_PLAYERS is the house; seats occupy 0..NUM_PLAYERS-1.
  localparam int HANDS  = NUM_PLAYERS + 1;
  localparam int TGT_W  = $clog2(HANDS);
  localparam int CNT_W  = $clog2(HAND_DEPTH + 1);
  localparam int DEAL_W = $clog2(2 * HANDS + 1);
  localparam int AX     = SUM_W + 2;

  localparam logic [AX-1:0]     BUST_X    = AX'(BUST_LIMIT);
  localparam logic [AX-1:0]     STAND_X   = AX'(HOUSE_STAND);
  localparam logic [AX-1:0]     SAT_X     = AX'((1 << SUM_W) - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(HAND_DEPTH);
  localparam logic [SEAT_W-1:0] LAST_SEAT = SEAT_W'(NUM_PLAYERS - 1);
  localparam logic [TGT_W-1:0]  HOUSE_IDX = TGT_W'(NUM_PLAYERS);
  localparam logic [DEAL_W-1:0] DEAL_LAST = DEAL_W'(2 * HANDS);

  localparam logic [1:0] RES_WIN  = 2'b01;
  localparam logic [1:0] RES_LOSE = 2'b10;
  localparam logic [1:0] RES_PUSH = 2'b11;

  typedef enum logic [3:0] {
    SHUFFLE_REQ,
    SHUFFLE_WAIT,
    READY,
    DEAL,
    CARD_REQ,
    CARD_WAIT,
    CARD_ADD,
    PLAY_CHECK,
    PLAY_WAIT,
    HOUSE_CHECK,
    SCORE,
    DONE,
    ERROR
  } state_t;

  state_t state, next_state, ret_state;

  logic start_s1, start_s2, start_prev;
  logic hit_s1, hit_s2, hit_prev;
  logic stand_s1, stand_s2, stand_prev;
  logic start_edge, hit_edge, stand_edge;

  logic [SUM_W-1:0] hand_sum  [HANDS];
  logic [CNT_W-1:0] hand_cnt  [HANDS];
  logic [CNT_W-1:0] hand_soft [HANDS];

  logic [TGT_W-1:0]       tgt;
  logic [TGT_W-1:0]       deal_tgt;
  logic [DEAL_W-1:0]      deal_idx;
  logic [3:0]             card_q;
  logic                   seat_stood;
  logic [SEAT_W-1:0]      active_seat_q;
  logic [2*NUM_PLAYERS-1:0] results_q;
  logic                   shuffle_start_q;
  logic                   card_start_q;

  logic [TGT_W-1:0] active_idx;
  logic [AX-1:0]    card_val;
  logic [AX-1:0]    add_sum;
  logic [CNT_W-1:0] add_soft;
  logic             seat_done;
  logic             all_bust;
  logic             house_bust;
  logic             house_draw;

  assign start_edge = start_s2 & ~start_prev;
  assign hit_edge   = hit_s2 & ~hit_prev;
  assign stand_edge = stand_s2 & ~stand_prev;

  assign active_idx = TGT_W'(active_seat_q);
  assign seat_done  = ({2'b00, hand_sum[active_idx]} >= BUST_X) ||
                      (hand_cnt[active_idx] == DEPTH_C) || seat_stood;
  assign house_bust = {2'b00, hand_sum[NUM_PLAYERS]} > BUST_X;
  assign house_draw = ({2'b00, hand_sum[NUM_PLAYERS]} < STAND_X) &&
                      (hand_cnt[NUM_PLAYERS] < DEPTH_C);

  // Two-flop synchronisers and edge history for the three raw buttons.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_s1 <= 1'b0; start_s2 <= 1'b0; start_prev <= 1'b0;
      hit_s1   <= 1'b0; hit_s2   <= 1'b0; hit_prev   <= 1'b0;
      stand_s1 <= 1'b0; stand_s2 <= 1'b0; stand_prev <= 1'b0;
    end else begin
      start_s1 <= start; start_s2 <= start_s1; start_prev <= start_s2;
      hit_s1   <= hit;   hit_s2   <= hit_s1;   hit_prev   <= hit_s2;
      stand_s1 <= stand; stand_s2 <= stand_s1; stand_prev <= stand_s2;
    end
  end

  // Score the sampled card into the target hand, demoting one soft ace on overflow.
  always_comb begin
    card_val = '0;
    if (card_q == 4'd1)
      card_val = AX'(11);
    else if (card_q <= 4'd9)
      card_val = AX'(card_q);
    else
      card_val = AX'(10);
    add_soft = hand_soft[tgt] + CNT_W'(card_q == 4'd1);
    add_sum  = {2'b00, hand_sum[tgt]} + card_val;
    if ((add_sum > BUST_X) && (add_soft != '0)) begin
      add_sum  = add_sum - AX'(10);
      add_soft = add_soft - 1'b1;
    end
    if (add_sum > SAT_X)
      add_sum = SAT_X;
  end

  // True when every seat is over the bust limit, which lets the house skip drawing.
  always_comb begin
    all_bust = 1'b1;
    for (int i = 0; i < NUM_PLAYERS; i++)
      if ({2'b00, hand_sum[i]} <= BUST_X)
        all_bust = 1'b0;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= SHUFFLE_REQ;
    else
      state <= next_state;
  end

  // Next-state logic; card fetches return to whichever state launched them.
  always_comb begin
    next_state = state;
    case (state)
      SHUFFLE_REQ:  if (shuffle_start_q && !shuffle_ready) next_state = SHUFFLE_WAIT;
      SHUFFLE_WAIT: if (shuffle_ready) next_state = READY;
      READY:        if (start_edge) next_state = DEAL;
      DEAL:         next_state = (deal_idx == DEAL_LAST) ? PLAY_CHECK : CARD_REQ;
      CARD_REQ:     if (card_start_q && !card_ready) next_state = CARD_WAIT;
      CARD_WAIT:    if (card_ready) next_state = card_overflow ? ERROR : CARD_ADD;
      CARD_ADD:     next_state = ret_state;
      PLAY_CHECK: begin
        if (!seat_done)
          next_state = PLAY_WAIT;
        else if (active_seat_q == LAST_SEAT)
          next_state = HOUSE_CHECK;
      end
      PLAY_WAIT: begin
        if (stand_edge)
          next_state = PLAY_CHECK;
        else if (hit_edge)
          next_state = CARD_REQ;
      end
      HOUSE_CHECK: begin
        if (all_bust || !house_draw)
          next_state = SCORE;
        else
          next_state = CARD_REQ;
      end
      SCORE:        next_state = DONE;
      DONE, ERROR:  if (start_edge) next_state = SHUFFLE_REQ;
      default:      next_state = SHUFFLE_REQ;
    endcase
  end

  // Datapath: deck requests, hand bookkeeping, seat sequencing and scoring.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shuffle_start_q <= 1'b0;
      card_start_q    <= 1'b0;
      ret_state       <= SHUFFLE_REQ;
      tgt             <= '0;
      deal_tgt        <= '0;
      deal_idx        <= '0;
      card_q          <= '0;
      seat_stood      <= 1'b0;
      active_seat_q   <= '0;
      results_q       <= '0;
      for (int i = 0; i < HANDS; i++) begin
        hand_sum[i]  <= '0;
        hand_cnt[i]  <= '0;
        hand_soft[i] <= '0;
      end
    end else begin
      shuffle_start_q <= (next_state == SHUFFLE_REQ);
      card_start_q    <= (next_state == CARD_REQ);
      case (state)
        READY: begin
          if (start_edge) begin
            results_q     <= '0;
            deal_idx      <= '0;
            deal_tgt      <= '0;
            active_seat_q <= '0;
            seat_stood    <= 1'b0;
            for (int i = 0; i < HANDS; i++) begin
              hand_sum[i]  <= '0;
              hand_cnt[i]  <= '0;
              hand_soft[i] <= '0;
            end
          end
        end
        DEAL: begin
          if (deal_idx == DEAL_LAST) begin
            active_seat_q <= '0;
          end else begin
            tgt       <= deal_tgt;
            ret_state <= DEAL;
            deal_idx  <= deal_idx + 1'b1;
            deal_tgt  <= (deal_tgt == HOUSE_IDX) ? '0 : deal_tgt + 1'b1;
          end
        end
        CARD_WAIT: begin
          if (card_ready) begin
            card_q <= card;
            if (card_overflow)
              results_q <= '0;
          end
        end
        CARD_ADD: begin
          hand_sum[tgt]  <= add_sum[SUM_W-1:0];
          hand_cnt[tgt]  <= hand_cnt[tgt] + 1'b1;
          hand_soft[tgt] <= add_soft;
        end
        PLAY_CHECK: begin
          if (seat_done) begin
            seat_stood <= 1'b0;
            if (active_seat_q != LAST_SEAT)
              active_seat_q <= active_seat_q + 1'b1;
          end
        end
        PLAY_WAIT: begin
          if (stand_edge) begin
            seat_stood <= 1'b1;
          end else if (hit_edge) begin
            tgt       <= active_idx;
            ret_state <= PLAY_CHECK;
          end
        end
        HOUSE_CHECK: begin
          tgt       <= HOUSE_IDX;
          ret_state <= HOUSE_CHECK;
        end
        SCORE: begin
          for (int i = 0; i < NUM_PLAYERS; i++) begin
            if ({2'b00, hand_sum[i]} > BUST_X)
              results_q[2*i +: 2] <= RES_LOSE;
            else if (house_bust)
              results_q[2*i +: 2] <= RES_WIN;
            else if (hand_sum[i] > hand_sum[NUM_PLAYERS])
              results_q[2*i +: 2] <= RES_WIN;
            else if (hand_sum[i] == hand_sum[NUM_PLAYERS])
              results_q[2*i +: 2] <= RES_PUSH;
            else
              results_q[2*i +: 2] <= RES_LOSE;
          end
        end
        ERROR: results_q <= '0;
        default: ;
      endcase
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_PLAYERS; g++) begin : g_sums
      assign player_sums[g*SUM_W +: SUM_W] = hand_sum[g];
    end
  endgenerate

  assign house_sum     = hand_sum[NUM_PLAYERS];
  assign active_seat   = active_seat_q;
  assign results       = results_q;
  assign shuffle_start = shuffle_start_q;
  assign card_start    = card_start_q;
  assign await_input   = (state == PLAY_WAIT);
  assign game_done     = (state == DONE);
  assign error         = (state == ERROR);

endmodule

// File: tb/tb_blackjack_table_ctrl.sv
// tb_blackjack_table_ctrl: directed games against a scripted deck model,
// with hand-computed sums and results for the default two-seat table.
module tb_blackjack_table_ctrl;

  logic        clk;
  logic        rst;
  logic        start, hit, stand;
  logic        shuffle_start, shuffle_ready;
  logic        card_start, card_ready;
  logic [3:0]  card;
  logic        card_overflow;
  logic [0:0]  active_seat;
  logic [11:0] player_sums;
  logic [5:0]  house_sum;
  logic [3:0]  results;
  logic        await_input, game_done, error;

  int checks   = 0;
  int failures = 0;

  int deck_q[$];
  int ovf_q[$];

  blackjack_table_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .hit           (hit),
    .stand         (stand),
    .shuffle_start (shuffle_start),
    .shuffle_ready (shuffle_ready),
    .card_start    (card_start),
    .card_ready    (card_ready),
    .card          (card),
    .card_overflow (card_overflow),
    .active_seat   (active_seat),
    .player_sums   (player_sums),
    .house_sum     (house_sum),
    .results       (results),
    .await_input   (await_input),
    .game_done     (game_done),
    .error         (error)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Shuffle side of the deck: drop ready for two cycles per request.
  initial begin
    shuffle_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (shuffle_start && shuffle_ready) begin
        shuffle_ready = 1'b0;
        repeat (2) @(negedge clk);
        shuffle_ready = 1'b1;
      end
    end
  end

  // Card side of the deck: serve the scripted cards in order.
  initial begin
    card_ready    = 1'b1;
    card          = 4'd0;
    card_overflow = 1'b0;
    forever begin
      @(negedge clk);
      if (card_start && card_ready) begin
        card_ready = 1'b0;
        repeat (2) @(negedge clk);
        card          = (deck_q.size() > 0) ? 4'(deck_q.pop_front()) : 4'd10;
        card_overflow = (ovf_q.size() > 0) ? (ovf_q.pop_front() != 0) : 1'b0;
        card_ready    = 1'b1;
      end
    end
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Raise the chosen raw buttons long enough for one synchronised edge.
  task automatic apply_stimulus(input logic s, input logic h, input logic st);
    @(negedge clk);
    start = s; hit = h; stand = st;
    repeat (3) @(negedge clk);
    start = 1'b0; hit = 1'b0; stand = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  function automatic logic pick(input int sel);
    case (sel)
      0:       return await_input;
      1:       return game_done;
      2:       return error;
      default: return card_start;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input logic level, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (pick(sel) === level) begin
        seen = 1'b1;
        break;
      end
    end
    check_output(tag, 32'(seen), 1);
  endtask

  task automatic new_game();
    apply_stimulus(1'b1, 1'b0, 1'b0);
    repeat (12) @(negedge clk);
    apply_stimulus(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; hit = 1'b0; stand = 1'b0;
    ovf_q.delete();
    repeat (3) @(negedge clk);
    check_output("rst_shuffle_start", 32'(shuffle_start), 0);
    check_output("rst_card_start", 32'(card_start), 0);
    check_output("rst_results", 32'(results), 0);
    check_output("rst_player_sums", 32'(player_sums), 0);
    check_output("rst_house_sum", 32'(house_sum), 0);
    check_output("rst_active_seat", 32'(active_seat), 0);
    check_output("rst_flags", 32'({await_input, game_done, error}), 0);
    rst = 1'b1;
    @(negedge clk);
    check_output("shuffle_start_after_rst", 32'(shuffle_start), 1);
    repeat (12) @(negedge clk);

    $display("[TB] game A: stand / hit to 21 / house stands on 17");
    deck_q = '{10, 5, 9, 7, 6, 8, 10};
    apply_stimulus(1'b1, 1'b0, 1'b0);
    wait_sig(0, 1'b1, "deal_A");
    check_output("A_seat0_sum", 32'(player_sums[5:0]), 17);
    check_output("A_seat1_sum", 32'(player_sums[11:6]), 11);
    check_output("A_house_sum", 32'(house_sum), 17);
    check_output("A_active0", 32'(active_seat), 0);
    apply_stimulus(1'b0, 1'b0, 1'b1);
    wait_sig(0, 1'b1, "A_stand_seat0");
    check_output("A_active1", 32'(active_seat), 1);
    apply_stimulus(1'b0, 1'b1, 1'b0);
    wait_sig(1, 1'b1, "A_done");
    check_output("A_seat1_final", 32'(player_sums[11:6]), 21);
    check_output("A_results", 32'(results), 4'b0111);

    $display("[TB] game B: soft ace and simultaneous hit+stand");
    deck_q = '{1, 10, 10, 6, 9, 7, 9, 5};
    apply_stimulus(1'b1, 1'b0, 1'b0);
    check_output("B_done_cleared", 32'(game_done), 0);
    check_output("B_results_held", 32'(results), 4'b0111);
    repeat (12) @(negedge clk);
    apply_stimulus(1'b1, 1'b0, 1'b0);
    wait_sig(0, 1'b1, "deal_B");
    check_output("B_results_cleared", 32'(results), 0);
    check_output("B_seat0_soft17", 32'(player_sums[5:0]), 17);
    check_output("B_seat1_sum", 32'(player_sums[11:6]), 19);
    apply_stimulus(1'b0, 1'b1, 1'b0);
    wait_sig(0, 1'b1, "B_hit_seat0");
    check_output("B_seat0_demoted", 32'(player_sums[5:0]), 16);
    check_output("B_still_seat0", 32'(active_seat), 0);
    apply_stimulus(1'b0, 1'b1, 1'b1);
    wait_sig(0, 1'b1, "B_hit_and_stand");
    check_output("B_active1", 32'(active_seat), 1);
    check_output("B_seat0_no_draw", 32'(player_sums[5:0]), 16);
    apply_stimulus(1'b0, 1'b1, 1'b0);
    wait_sig(1, 1'b1, "B_done");
    check_output("B_seat1_bust", 32'(player_sums[11:6]), 24);
    check_output("B_results", 32'(results), 4'b1010);

    $display("[TB] game C: every seat busts, house draws nothing");
    deck_q = '{10, 10, 6, 5, 6, 4, 10, 10, 9, 9};
    new_game();
    wait_sig(0, 1'b1, "deal_C");
    check_output("C_house_dealt", 32'(house_sum), 10);
    apply_stimulus(1'b0, 1'b1, 1'b0);
    wait_sig(0, 1'b1, "C_hit_seat0");
    check_output("C_seat0_bust", 32'(player_sums[5:0]), 25);
    check_output("C_active1", 32'(active_seat), 1);
    apply_stimulus(1'b0, 1'b1, 1'b0);
    wait_sig(1, 1'b1, "C_done");
    check_output("C_house_unchanged", 32'(house_sum), 10);
    check_output("C_cards_left", 32'(deck_q.size()), 2);
    check_output("C_results", 32'(results), 4'b1010);

    $display("[TB] game D: hand depth auto-finish, house draws and busts");
    deck_q = '{2, 10, 10, 2, 10, 6, 2, 2, 3, 10};
    new_game();
    wait_sig(0, 1'b1, "deal_D");
    check_output("D_seat0_dealt", 32'(player_sums[5:0]), 4);
    check_output("D_house_dealt", 32'(house_sum), 16);
    apply_stimulus(1'b0, 1'b1, 1'b0);
    wait_sig(0, 1'b1, "D_hit1");
    apply_stimulus(1'b0, 1'b1, 1'b0);
    wait_sig(0, 1'b1, "D_hit2");
    check_output("D_seat0_four_cards", 32'(player_sums[5:0]), 8);
    check_output("D_still_seat0", 32'(active_seat), 0);
    apply_stimulus(1'b0, 1'b1, 1'b0);
    wait_sig(0, 1'b1, "D_hit3");
    check_output("D_seat0_five_cards", 32'(player_sums[5:0]), 11);
    check_output("D_auto_advance", 32'(active_seat), 1);
    apply_stimulus(1'b0, 1'b0, 1'b1);
    wait_sig(1, 1'b1, "D_done");
    check_output("D_house_bust", 32'(house_sum), 26);
    check_output("D_results", 32'(results), 4'b0101);

    $display("[TB] game E: deck overflow on the third deal card");
    deck_q = '{10, 10, 10};
    ovf_q  = '{0, 0, 1};
    new_game();
    wait_sig(2, 1'b1, "E_error");
    check_output("E_results_zero", 32'(results), 0);
    check_output("E_flags", 32'({await_input, game_done}), 0);
    @(negedge clk);
    start = 1'b1;
    wait_sig(2, 1'b0, "E_error_exit");
    check_output("E_reshuffle", 32'(shuffle_start), 1);
    start = 1'b0;
    ovf_q.delete();
    repeat (12) @(negedge clk);

    $display("[TB] game F: reset during the house draw");
    deck_q = '{10, 10, 2, 8, 9, 3, 7};
    apply_stimulus(1'b1, 1'b0, 1'b0);
    wait_sig(0, 1'b1, "deal_F");
    check_output("F_house_dealt", 32'(house_sum), 5);
    apply_stimulus(1'b0, 1'b0, 1'b1);
    wait_sig(0, 1'b1, "F_stand_seat0");
    check_output("F_active1", 32'(active_seat), 1);
    apply_stimulus(1'b0, 1'b0, 1'b1);
    wait_sig(3, 1'b1, "F_house_fetch");
    rst = 1'b0;
    #1;
    check_output("F_rst_card_start", 32'(card_start), 0);
    check_output("F_rst_shuffle_start", 32'(shuffle_start), 0);
    check_output("F_rst_sums", 32'({player_sums, house_sum}), 0);
    check_output("F_rst_results", 32'(results), 0);
    check_output("F_rst_active", 32'(active_seat), 0);
    check_output("F_rst_flags", 32'({await_input, game_done, error}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_output("F_shuffle_after_rst", 32'(shuffle_start), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
